// File: rtl/rsa_arbiter.sv
// rsa_arbiter
// Round-robin arbiter and sequencer sharing one RSA core among NUM_REQ
// requesters. The granted requester's operand and operation are latched,
// the core is walked through reset / wait-ready-low / run / wait-ready-high,
// and the result is returned with a one-cycle done pulse. A watchdog aborts
// operations whose core never completes.
module rsa_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int MOD_VALUE      = 3233,
  parameter int PUB_KEY        = 17,
  parameter int PRIV_KEY       = 2753,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         rsa_datain,
  output logic [DATA_WIDTH-1:0]         rsa_modulusin,
  output logic [DATA_WIDTH-1:0]         rsa_keyin,
  output logic                          rsa_rst,
  output logic                          rsa_en,
  input  logic [DATA_WIDTH-1:0]         rsa_dataout,
  input  logic                          rsa_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [DATA_WIDTH-1:0] MOD_L  = DATA_WIDTH'(MOD_VALUE);
  localparam logic [DATA_WIDTH-1:0] PUB_L  = DATA_WIDTH'(PUB_KEY);
  localparam logic [DATA_WIDTH-1:0] PRIV_L = DATA_WIDTH'(PRIV_KEY);
  localparam logic [15:0]           WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0]    ONE_L   = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]        NUM_L    = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST      = 3'd1,
    S_WAIT_LOW = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 state_q,  state_d;
  logic [IDX_W-1:0]       ptr_q,    ptr_d;
  logic [IDX_W-1:0]       gidx_q,   gidx_d;
  logic [15:0]            wd_q,     wd_d;
  logic [NUM_REQ-1:0]     grant_q,  grant_d;
  logic [NUM_REQ-1:0]     done_q,   done_d;
  logic                   err_q,    err_d;
  logic                   busy_q,   busy_d;
  logic                   rst_q,    rst_d;
  logic                   en_q,     en_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic [DATA_WIDTH-1:0]  datain_q, datain_d;
  logic [DATA_WIDTH-1:0]  mod_q,    mod_d;
  logic [DATA_WIDTH-1:0]  key_q,    key_d;

  logic                   win_found_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic [IDX_W:0]         cand_s;
  logic [IDX_W-1:0]       ptr_next_s;

  // Round-robin scan: first asserted request at or after the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand_s >= NUM_L) begin
        cand_s = cand_s - NUM_L;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req[cand_s[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pointer value after the current owner finishes: owner index + 1, wrapping.
  always_comb begin
    if (gidx_q == LAST_IDX) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gidx_q + IDX_W'(1);
    end
  end

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    wd_d     = wd_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = err_q;
    busy_d   = busy_q;
    rst_d    = 1'b0;
    en_d     = en_q;
    result_d = result_q;
    datain_d = datain_q;
    mod_d    = mod_q;
    key_d    = key_q;

    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d  = S_RST;
          gidx_d   = win_idx_s;
          grant_d  = ONE_L << win_idx_s;
          datain_d = req_data[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
          mod_d    = MOD_L;
          key_d    = req_op[win_idx_s] ? PRIV_L : PUB_L;
          rst_d    = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d  = S_IDLE;
          grant_d  = '0;
          busy_d   = 1'b0;
          en_d     = 1'b0;
        end
      end

      S_RST: begin
        // Core reset lasts exactly this one cycle; watchdog starts fresh.
        state_d = S_WAIT_LOW;
        wd_d    = 16'd0;
        rst_d   = 1'b0;
        en_d    = 1'b0;
      end

      S_WAIT_LOW: begin
        wd_d = wd_q + 16'd1;
        if (!rsa_ready) begin
          state_d = S_RUN;
          en_d    = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d  = S_DONE;
          en_d     = 1'b0;
          err_d    = 1'b1;
          result_d = '0;
          done_d   = grant_q;
          ptr_d    = ptr_next_s;
        end else begin
          state_d = S_WAIT_LOW;
        end
      end

      S_RUN: begin
        wd_d = wd_q + 16'd1;
        if (rsa_ready) begin
          state_d  = S_DONE;
          en_d     = 1'b0;
          err_d    = 1'b0;
          result_d = rsa_dataout;
          done_d   = grant_q;
          ptr_d    = ptr_next_s;
        end else if (wd_q == WD_LAST) begin
          state_d  = S_DONE;
          en_d     = 1'b0;
          err_d    = 1'b1;
          result_d = '0;
          done_d   = grant_q;
          ptr_d    = ptr_next_s;
        end else begin
          state_d = S_RUN;
          en_d    = 1'b1;
        end
      end

      S_DONE: begin
        // Release the core; the next grant can come at the earliest one
        // idle cycle later.
        state_d  = S_IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        en_d     = 1'b0;
        datain_d = '0;
        mod_d    = '0;
        key_d    = '0;
      end

      default: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        en_d     = 1'b0;
        datain_d = '0;
        mod_d    = '0;
        key_d    = '0;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      wd_q     <= 16'd0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rst_q    <= 1'b0;
      en_q     <= 1'b0;
      result_q <= '0;
      datain_q <= '0;
      mod_q    <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      wd_q     <= wd_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      rst_q    <= rst_d;
      en_q     <= en_d;
      result_q <= result_d;
      datain_q <= datain_d;
      mod_q    <= mod_d;
      key_q    <= key_d;
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign err           = err_q;
  assign result        = result_q;
  assign busy          = busy_q;
  assign rsa_datain    = datain_q;
  assign rsa_modulusin = mod_q;
  assign rsa_keyin     = key_q;
  assign rsa_rst       = rst_q;
  assign rsa_en        = en_q;

endmodule

// File: tb/tb_rsa_arbiter.sv
// Directed testbench for rsa_arbiter with a behavioural RSA core model
// (modular exponentiation, fixed latency after enable, optional hang).
module tb_rsa_arbiter;

  localparam int CORE_LAT = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_op;
  logic [63:0] req_data;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        err;
  logic [31:0] result;
  logic        busy;
  logic [31:0] rsa_datain;
  logic [31:0] rsa_modulusin;
  logic [31:0] rsa_keyin;
  logic        rsa_rst;
  logic        rsa_en;
  logic [31:0] core_out = 32'd0;
  logic        core_rdy = 1'b1;
  int          core_cnt = 0;
  logic        hang = 1'b0;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int n;

  rsa_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(32), .MOD_VALUE(3233),
    .PUB_KEY(17), .PRIV_KEY(2753), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .result(result), .busy(busy),
    .rsa_datain(rsa_datain), .rsa_modulusin(rsa_modulusin), .rsa_keyin(rsa_keyin),
    .rsa_rst(rsa_rst), .rsa_en(rsa_en), .rsa_dataout(core_out), .rsa_ready(core_rdy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m);
    longint r;
    longint x;
    if (m == 32'd0) return 32'd0;
    r = 1;
    x = longint'(b) % longint'(m);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % longint'(m);
      x = (x * x) % longint'(m);
    end
    return 32'(r);
  endfunction

  // Core model: ready drops on reset, rises CORE_LAT enabled cycles later.
  always @(posedge clock) begin
    if (rsa_rst) begin
      core_rdy <= 1'b0;
      core_cnt <= 0;
    end else if (rsa_en && !core_rdy && !hang) begin
      if (core_cnt == CORE_LAT - 1) begin
        core_rdy <= 1'b1;
        core_out <= modexp(rsa_datain, rsa_keyin, rsa_modulusin);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  // Running invariants: grant one-hot or zero, never enable during core reset.
  always @(negedge clock) begin
    if (reset === 1'b1 && (!$onehot0(grant) || (rsa_en && rsa_rst)))
      viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int cyc);
    bit hit = 1'b0;
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      if (!hit) begin
        @(negedge clock);
        if (grant != 2'b00) begin hit = 1'b1; cyc = i; end
      end
    end
  endtask

  task automatic wait_done(output int cyc);
    bit hit = 1'b0;
    cyc = 99;
    for (int i = 1; i <= 40; i++) begin
      if (!hit) begin
        @(negedge clock);
        if (done != 2'b00) begin hit = 1'b1; cyc = i; end
      end
    end
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; req_op = 2'b00; req_data = 64'd0;
    repeat (2) @(negedge clock);
    chk("rst_grant",  32'(grant), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_mod",    rsa_modulusin, 32'd0);
    chk("rst_key",    rsa_keyin, 32'd0);
    chk("rst_rstout", 32'(rsa_rst), 32'd0);
    chk("rst_en",     32'(rsa_en), 32'd0);
    reset = 1'b1;

    // 1: single encrypt, latency and core-side values
    req_data[31:0] = 32'd65; req_op = 2'b00; req = 2'b01;
    @(negedge clock);
    chk("t1_grant",  32'(grant), 32'd1);
    chk("t1_rsarst", 32'(rsa_rst), 32'd1);
    chk("t1_busy",   32'(busy), 32'd1);
    chk("t1_key",    rsa_keyin, 32'd17);
    chk("t1_mod",    rsa_modulusin, 32'd3233);
    chk("t1_datain", rsa_datain, 32'd65);
    chk("t1_en0",    32'(rsa_en), 32'd0);
    @(negedge clock);
    chk("t1_rsarst_low", 32'(rsa_rst), 32'd0);
    chk("t1_en_wait",    32'(rsa_en), 32'd0);
    @(negedge clock);
    chk("t1_en_run", 32'(rsa_en), 32'd1);
    wait_done(n);
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_done",    32'(done), 32'd1);
    chk("t1_result",  result, 32'd2790);
    chk("t1_err",     32'(err), 32'd0);
    req = 2'b00;
    @(negedge clock);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_busy",  32'(busy), 32'd0);
    chk("t1_idle_mod",   rsa_modulusin, 32'd0);
    chk("t1_result_hold", result, 32'd2790);

    // fresh pointer for the ordering scenario
    reset = 1'b0;
    @(negedge clock);
    chk("t2_rst_result", result, 32'd0);
    reset = 1'b1;

    // 2: simultaneous decrypts, round-robin order twice
    req_data = {32'd2790, 32'd2790}; req_op = 2'b11; req = 2'b11;
    wait_grant(n);
    chk("t2_a_lat",   32'(n), 32'd1);
    chk("t2_a_grant", 32'(grant), 32'd1);
    chk("t2_a_key",   rsa_keyin, 32'd2753);
    wait_done(n);
    chk("t2_a_done",   32'(done), 32'd1);
    chk("t2_a_result", result, 32'd65);
    req = 2'b10;
    @(negedge clock);
    chk("t2_gap_grant", 32'(grant), 32'd0);
    chk("t2_gap_busy",  32'(busy), 32'd0);
    @(negedge clock);
    chk("t2_b_grant", 32'(grant), 32'd2);
    chk("t2_b_key",   rsa_keyin, 32'd2753);
    wait_done(n);
    chk("t2_b_lat",    32'(n), 32'd8);
    chk("t2_b_done",   32'(done), 32'd2);
    chk("t2_b_result", result, 32'd65);
    req = 2'b11;
    wait_grant(n);
    chk("t2_c_lat",   32'(n), 32'd2);
    chk("t2_c_grant", 32'(grant), 32'd1);
    chk("t2_c_key",   rsa_keyin, 32'd2753);
    wait_done(n);
    chk("t2_c_done", 32'(done), 32'd1);
    req = 2'b10;
    wait_grant(n);
    chk("t2_d_grant", 32'(grant), 32'd2);
    chk("t2_d_key",   rsa_keyin, 32'd2753);
    wait_done(n);
    chk("t2_d_done", 32'(done), 32'd2);
    req = 2'b00;

    // 3: hung core, watchdog abort, then normal service
    hang = 1'b1;
    req_data[31:0] = 32'd65; req_op = 2'b10; req = 2'b01;
    wait_grant(n);
    chk("t3_grant", 32'(grant), 32'd1);
    wait_done(n);
    chk("t3_timeout_lat", 32'(n), 32'd9);
    chk("t3_done",   32'(done), 32'd1);
    chk("t3_err",    32'(err), 32'd1);
    chk("t3_result", result, 32'd0);
    hang = 1'b0;
    req_data[63:32] = 32'd2790; req_op = 2'b10; req = 2'b10;
    wait_grant(n);
    chk("t3_next_grant", 32'(grant), 32'd2);
    wait_done(n);
    chk("t3_next_done",   32'(done), 32'd2);
    chk("t3_next_err",    32'(err), 32'd0);
    chk("t3_next_result", result, 32'd65);

    // 4: async reset during RUN
    req_data[31:0] = 32'd65; req_op = 2'b00; req = 2'b01;
    wait_grant(n);
    chk("t4_grant", 32'(grant), 32'd1);
    repeat (2) @(negedge clock);
    chk("t4_en_before", 32'(rsa_en), 32'd1);
    #2;
    reset = 1'b0; req = 2'b00;
    #1;
    chk("t4_async_grant", 32'(grant), 32'd0);
    chk("t4_async_en",    32'(rsa_en), 32'd0);
    chk("t4_async_busy",  32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t4_no_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    req = 2'b01;
    wait_grant(n);
    chk("t4_fresh_lat",   32'(n), 32'd1);
    chk("t4_fresh_grant", 32'(grant), 32'd1);
    wait_done(n);
    chk("t4_fresh_done_lat", 32'(n), 32'd8);
    chk("t4_fresh_result",   result, 32'd2790);
    chk("t4_fresh_err",      32'(err), 32'd0);

    // 5: requester 1 drops req and scrambles its inputs after grant
    req_data[63:32] = 32'd2790; req_op = 2'b10; req = 2'b10;
    wait_grant(n);
    chk("t5_grant", 32'(grant), 32'd2);
    repeat (2) @(negedge clock);
    req = 2'b00; req_data[63:32] = 32'd0; req_op = 2'b00;
    @(negedge clock);
    chk("t5_datain_latched", rsa_datain, 32'd2790);
    chk("t5_key_latched",    rsa_keyin, 32'd2753);
    wait_done(n);
    chk("t5_done",   32'(done), 32'd2);
    chk("t5_result", result, 32'd65);

    // 6: continuous contention over ten operations
    req_data = {32'd2790, 32'd65}; req_op = 2'b10; req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      wait_grant(n);
      chk("t6_gap", 32'(n), 32'd2);
      chk("t6_grant", 32'(grant), (i % 2 == 0) ? 32'd1 : 32'd2);
      wait_done(n);
      chk("t6_done", 32'(done), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("t6_result", result, (i % 2 == 0) ? 32'd2790 : 32'd65);
    end
    req = 2'b00;
    repeat (2) @(negedge clock);
    chk("invariants", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
